// File: rtl/icache_prefetch.sv
// Direct-mapped read-only instruction cache, optional next-line prefetch after each demand fill.
// Latency: hits serve in the same cycle; miss = 1 + memory latency + 1 cycles. Backpressure: BUSYWAIT stalls CPU, IMEM_BUSYWAIT stalls fills.
module icache_prefetch #(
    parameter int ADDR_W   = 10,
    parameter int LINES    = 8,
    parameter int WORDS    = 4,
    parameter int PREFETCH = 0,
    localparam int OFF     = $clog2(WORDS),
    localparam int IDX     = $clog2(LINES),
    localparam int TAG_W   = ADDR_W - 2 - OFF - IDX,
    localparam int BLK_W   = ADDR_W - 2 - OFF,
    localparam int OFF_W   = (OFF > 0) ? OFF : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           PC,
    output logic [31:0]           INSTRUCTION,
    output logic                  BUSYWAIT,
    output logic                  IMEM_READ,
    output logic [BLK_W-1:0]      IMEM_ADDRESS,
    input  logic [32*WORDS-1:0]   IMEM_READDATA,
    input  logic                  IMEM_BUSYWAIT,
    output logic [15:0]           HIT_COUNT,
    output logic [15:0]           MISS_COUNT
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PF} state_t;

    state_t                 state_q, state_d;
    logic [BLK_W-1:0]       req_q, req_d;
    logic                   rd_q, rd_d;
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [32*WORDS-1:0]    data_q [LINES];
    logic [15:0]            hit_cnt_q, miss_cnt_q;

    logic [BLK_W-1:0]       pc_blk;
    logic [IDX-1:0]         pc_idx;
    logic [TAG_W-1:0]       pc_tag;
    logic [OFF_W-1:0]       pc_word;
    logic [32*WORDS-1:0]    pc_line;
    logic                   hit;
    logic [BLK_W-1:0]       next_blk;
    logic                   next_resident;
    logic                   pf_serve;
    logic                   busy, hit_inc, miss_inc, line_wr;
    logic                   unused_pc;

    assign pc_blk = PC[ADDR_W-1:OFF+2];
    assign pc_idx = pc_blk[IDX-1:0];
    assign pc_tag = pc_blk[BLK_W-1:IDX];
    assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};

    generate
        if (WORDS > 1) begin : g_word
            assign pc_word = PC[OFF+1:2];
        end else begin : g_single
            assign pc_word = '0;
        end
    endgenerate

    assign hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign pc_line = data_q[pc_idx];

    assign next_blk      = req_q + 1'b1;
    assign next_resident = valid_q[next_blk[IDX-1:0]] && (tag_q[next_blk[IDX-1:0]] == next_blk[BLK_W-1:IDX]);
    // While prefetching, only the line being filled is off-limits to the CPU.
    assign pf_serve      = hit && (pc_idx != req_q[IDX-1:0]);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rd_d     = rd_q;
        busy     = 1'b1;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        line_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = !hit;
                if (hit) begin
                    hit_inc = 1'b1;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = S_FILL;
                    req_d    = pc_blk;
                    rd_d     = 1'b1;
                end
            end
            S_FILL: begin
                if (!IMEM_BUSYWAIT) begin
                    line_wr = 1'b1;
                    if ((PREFETCH != 0) && !next_resident) begin
                        state_d = S_PF;
                        req_d   = next_blk;
                    end else begin
                        state_d = S_IDLE;
                        rd_d    = 1'b0;
                    end
                end
            end
            S_PF: begin
                busy    = !pf_serve;
                hit_inc = pf_serve;
                if (!IMEM_BUSYWAIT) begin
                    line_wr = 1'b1;
                    state_d = S_IDLE;
                    rd_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held.
    assign BUSYWAIT     = RESET & busy;
    assign INSTRUCTION  = RESET ? pc_line[32*pc_word +: 32] : 32'd0;
    assign IMEM_READ    = rd_q;
    assign IMEM_ADDRESS = req_q;
    assign HIT_COUNT    = hit_cnt_q;
    assign MISS_COUNT   = miss_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            rd_q       <= 1'b0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            if (line_wr) begin
                valid_q[req_q[IDX-1:0]] <= 1'b1;
            end
            if (hit_inc && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (miss_inc && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    // Tag and data need no reset: the valid bit qualifies them.
    always_ff @(posedge CLK) begin
        if (line_wr && RESET) begin
            tag_q[req_q[IDX-1:0]]  <= req_q[BLK_W-1:IDX];
            data_q[req_q[IDX-1:0]] <= IMEM_READDATA;
        end
    end

endmodule

// File: tb/tb_icache_prefetch.sv
// Bench for icache_prefetch: two instances (prefetch off / on) against a block-level cache model.
module tb_icache_prefetch;
    localparam int ADDR_W = 10;
    localparam int LINES  = 8;
    localparam int WORDS  = 4;
    localparam int BLK_W  = 6;
    localparam int NBLK   = 64;
    localparam int LAT    = 5;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic [31:0]        pc     [2];
    logic [31:0]        instr  [2];
    logic               bsy    [2];
    logic               rd     [2];
    logic [BLK_W-1:0]   addr   [2];
    logic [127:0]       rdata  [2];
    logic               mbw    [2];
    logic [15:0]        hits   [2];
    logic [15:0]        misses [2];

    int passed = 0;
    int total  = 0;

    function automatic logic [127:0] mem_blk(input logic [BLK_W-1:0] b);
        logic [127:0] r;
        for (int k = 0; k < WORDS; k++) begin
            r[32*k +: 32] = 32'hC0DE_0000 | (32'(b) * 32'd4 + 32'(k));
        end
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | ((a >> 2) & 32'd255);
    endfunction

    assign rdata[0] = mem_blk(addr[0]);
    assign rdata[1] = mem_blk(addr[1]);

    icache_prefetch #(.ADDR_W(ADDR_W), .LINES(LINES), .WORDS(WORDS), .PREFETCH(0)) u_np (
        .CLK(clk), .RESET(rst_n), .PC(pc[0]), .INSTRUCTION(instr[0]), .BUSYWAIT(bsy[0]),
        .IMEM_READ(rd[0]), .IMEM_ADDRESS(addr[0]), .IMEM_READDATA(rdata[0]),
        .IMEM_BUSYWAIT(mbw[0]), .HIT_COUNT(hits[0]), .MISS_COUNT(misses[0]));

    icache_prefetch #(.ADDR_W(ADDR_W), .LINES(LINES), .WORDS(WORDS), .PREFETCH(1)) u_pf (
        .CLK(clk), .RESET(rst_n), .PC(pc[1]), .INSTRUCTION(instr[1]), .BUSYWAIT(bsy[1]),
        .IMEM_READ(rd[1]), .IMEM_ADDRESS(addr[1]), .IMEM_READDATA(rdata[1]),
        .IMEM_BUSYWAIT(mbw[1]), .HIT_COUNT(hits[1]), .MISS_COUNT(misses[1]));

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Memory: busy for LAT cycles after a request is seen, then one ready cycle.
    int lat_cnt [2];
    initial begin
        mbw[0] = 1'b1;
        mbw[1] = 1'b1;
    end
    always @(negedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n || !rd[i]) begin
                mbw[i]     = 1'b1;
                lat_cnt[i] = 0;
            end else if (lat_cnt[i] < LAT) begin
                mbw[i]     = 1'b1;
                lat_cnt[i] = lat_cnt[i] + 1;
            end else begin
                mbw[i]     = 1'b0;
                lat_cnt[i] = 0;
            end
        end
    end

    // Model: which block each line holds, plus at most one outstanding block request.
    int res  [2][LINES];
    bit pend [2];
    bit ppf  [2];
    int pblk [2];
    int mh   [2];
    int mm   [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                for (int l = 0; l < LINES; l++) res[i][l] = -1;
                pend[i] = 0; ppf[i] = 0; pblk[i] = 0; mh[i] = 0; mm[i] = 0;
            end else begin
                int b;
                int nb;
                b = int'((pc[i] >> 4) % NBLK);
                if (!pend[i]) begin
                    if (res[i][b % LINES] == b) mh[i] = (mh[i] < 65535) ? mh[i] + 1 : mh[i];
                    else begin
                        mm[i] = (mm[i] < 65535) ? mm[i] + 1 : mm[i];
                        pend[i] = 1; ppf[i] = 0; pblk[i] = b;
                    end
                end else begin
                    if (ppf[i] && res[i][b % LINES] == b && (b % LINES) != (pblk[i] % LINES))
                        mh[i] = (mh[i] < 65535) ? mh[i] + 1 : mh[i];
                    if (!mbw[i]) begin
                        res[i][pblk[i] % LINES] = pblk[i];
                        nb = (pblk[i] + 1) % NBLK;
                        if (!ppf[i] && i == 1 && res[i][nb % LINES] != nb) begin
                            pblk[i] = nb; ppf[i] = 1;
                        end else begin
                            pend[i] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                int b;
                bit h;
                bit eb;
                b  = int'((pc[i] >> 4) % NBLK);
                h  = (res[i][b % LINES] == b);
                eb = pend[i] ? (ppf[i] ? !(h && (b % LINES) != (pblk[i] % LINES)) : 1'b1) : !h;
                chk($sformatf("busywait%0d", i), bsy[i], eb);
                chk($sformatf("imem_read%0d", i), rd[i], pend[i]);
                if (pend[i]) chk($sformatf("imem_addr%0d", i), addr[i], pblk[i]);
                chk($sformatf("hit_count%0d", i), hits[i], mh[i]);
                chk($sformatf("miss_count%0d", i), misses[i], mm[i]);
                if (!eb) chk($sformatf("instruction%0d", i), instr[i], mem_word(pc[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int i);
        for (int k = 0; k < 60; k++) begin
            if (!bsy[i] && !rd[i]) break;
            step();
        end
        chk($sformatf("idle_busy%0d", i), bsy[i], 0);
        chk($sformatf("idle_read%0d", i), rd[i], 0);
    endtask

    initial begin
        int n;
        pc[0] = 32'h0;
        pc[1] = 32'h0;
        #1;
        rst_n = 1'b0;
        #1;
        step();
        chk("rst_busy", bsy[0], 0);
        chk("rst_read", rd[0], 0);
        chk("rst_addr", addr[0], 0);
        chk("rst_hits", hits[0], 0);
        chk("rst_miss", misses[0], 0);
        chk("rst_instr", instr[0], 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_miss", bsy[0], 1);

        // Cold miss, no prefetch
        step();
        chk("cold_addr", addr[0], 0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!rd[0]) break;
            n++;
            step();
        end
        chk("cold_read_cycles", n, 6);
        chk("cold_first_busy", bsy[0], 0);
        chk("cold_w0", instr[0], 32'hC0DE_0000);
        step(); pc[0] = 32'h004; #1;
        chk("cold_w1", instr[0], 32'hC0DE_0001);
        step(); pc[0] = 32'h008;
        step(); pc[0] = 32'h00C; #1;
        chk("cold_w3_busy", bsy[0], 0);
        chk("cold_w3", instr[0], 32'hC0DE_0003);
        step();
        chk("cold_hits", hits[0], 4);
        chk("cold_miss", misses[0], 1);

        // Conflict on index 0
        pc[0] = 32'h080; #1;
        chk("conf_busy", bsy[0], 1);
        step();
        chk("conf_addr", addr[0], 8);
        wait_idle(0);
        chk("conf_instr", instr[0], 32'hC0DE_0020);
        pc[0] = 32'h000; #1;
        chk("conf_back_busy", bsy[0], 1);
        step();
        wait_idle(0);
        chk("conf_miss", misses[0], 3);

        // Prefetch after demand fill
        do_reset();
        pc[1] = 32'h000;
        step();
        for (int k = 0; k < 40; k++) begin
            if (rd[1] && addr[1] == 6'd1) break;
            step();
        end
        chk("pf_addr", addr[1], 1);
        chk("pf_read", rd[1], 1);
        pc[1] = 32'h004; #1;
        chk("pf_hit_busy", bsy[1], 0);
        chk("pf_hit_instr", instr[1], 32'hC0DE_0001);
        step();
        pc[1] = 32'h010; #1;
        chk("pf_stall", bsy[1], 1);
        for (int k = 0; k < 40; k++) begin
            if (!bsy[1]) break;
            step();
        end
        chk("pf_done_busy", bsy[1], 0);
        chk("pf_done_read", rd[1], 0);
        chk("pf_done_instr", instr[1], 32'hC0DE_0004);
        chk("pf_miss", misses[1], 1);

        // Prefetch address wraps to block 0
        do_reset();
        pc[1] = 32'h3F0;
        step();
        chk("wrap_fill_addr", addr[1], 63);
        for (int k = 0; k < 40; k++) begin
            if (rd[1] && addr[1] == 6'd0) break;
            step();
        end
        chk("wrap_pf_addr", addr[1], 0);
        chk("wrap_pf_read", rd[1], 1);
        wait_idle(1);
        pc[1] = 32'h000; #1;
        chk("wrap_hit_busy", bsy[1], 0);
        chk("wrap_hit_instr", instr[1], 32'hC0DE_0000);
        chk("wrap_miss", misses[1], 1);

        // Reset aborts an in-flight fill
        do_reset();
        pc[0] = 32'h040;
        step();
        step();
        step();
        chk("abort_read_before", rd[0], 1);
        rst_n = 1'b0;
        #1;
        chk("abort_read", rd[0], 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("abort_remiss", bsy[0], 1);
        step();
        wait_idle(0);
        chk("abort_instr", instr[0], 32'hC0DE_0010);
        chk("abort_miss", misses[0], 1);

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/icache_prefetch.md
# icache_prefetch

Parametrised direct-mapped, read-only instruction cache between the CPU's PC/INSTRUCTION fetch port and a block-wide instruction memory. It replaces the testbench-level combinational instruction array with a stalling fetch path: a BUSYWAIT handshake toward the CPU and a block-read handshake toward instruction memory. Cache geometry and an optional next-line prefetch mode are parameters. Saturating hit/miss counters support performance runs.

## Interface
- ADDR_W, 10, byte-address bits of PC used; PC[31:ADDR_W] ignored
- LINES, 8, number of cache lines (power of 2, ≥2)
- WORDS, 4, 32-bit words per block (power of 2, ≥1)
- PREFETCH, 0, 1 enables next-line prefetch after every demand fill
- Derived: OFF=log2(WORDS), IDX=log2(LINES), TAG_W=ADDR_W-2-OFF-IDX (must be ≥1), BLK_W=ADDR_W-2-OFF
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-low reset
- PC  in  32  fetch byte address; PC[1:0] ignored
- INSTRUCTION  out  32  fetched word; valid while BUSYWAIT=0
- BUSYWAIT  out  1  CPU stall request
- IMEM_READ  out  1  block read request
- IMEM_ADDRESS  out  BLK_W  block address, PC[ADDR_W-1:OFF+2]
- IMEM_READDATA  in  32*WORDS  block data; word k at bits [32k+31:32k]
- IMEM_BUSYWAIT  in  1  memory busy; block valid on the edge where it is low with IMEM_READ high
- HIT_COUNT  out  16  saturating hit counter
- MISS_COUNT  out  16  saturating demand-miss counter

## Operation
- Address split: word=PC[OFF+1:2], index=PC[OFF+IDX+1:OFF+2], tag=PC[ADDR_W-1:OFF+IDX+2].
- Per line: valid bit, TAG_W tag, 32*WORDS data. Hit = valid && tag match. Hit detection and INSTRUCTION word select are combinational.
- States: IDLE, FILL, PREFETCH.
- IDLE:
  - On a hit: BUSYWAIT=0. Each rising edge increments HIT_COUNT.
  - On a miss: BUSYWAIT=1 combinationally. Next edge increments MISS_COUNT and enters FILL.
- FILL:
  - IMEM_READ=1; IMEM_ADDRESS is the missed block, latched at FILL entry. BUSYWAIT=1.
  - On the edge with IMEM_BUSYWAIT=0: write data, tag and valid into the line.
  - Then go to PREFETCH if PREFETCH=1 and block+1 is not resident; otherwise go to IDLE.
- PREFETCH:
  - IMEM_READ=1; IMEM_ADDRESS = fill block + 1, modulo 2^BLK_W (wraps to 0).
  - CPU hits to any index other than the prefetch index are served (BUSYWAIT=0, counted as hits).
  - A miss, or any access to the prefetch index, holds BUSYWAIT=1.
  - On the completion edge: write the line, go to IDLE, and re-evaluate the lookup. A miss after prefetch completion counts as a normal miss. Prefetch completion never increments MISS_COUNT.
- Counters saturate at 0xFFFF. A line is never written while partially filled.
- PC change during FILL or PREFETCH does not alter the latched request.

## Timing
- Reset (RESET=0) forces the following, asynchronously and immediately:
  - state IDLE; all valid bits 0
  - IMEM_READ=0, IMEM_ADDRESS=0
  - HIT_COUNT=MISS_COUNT=0
  - BUSYWAIT=0, INSTRUCTION=0 while reset is held
- Reset mid-FILL or mid-PREFETCH aborts the request: IMEM_READ drops with no line write. The same PC misses after release.
- Hit latency: 0 cycles; INSTRUCTION is valid in the same cycle PC is presented.
- Miss penalty: 1 (IDLE→FILL) + N cycles (IMEM_BUSYWAIT high) + 1 (first IDLE cycle, served as a hit).
- IMEM_READ is registered and goes high on the edge entering FILL or PREFETCH. It goes low on the completion edge, except that it stays high when going FILL→PREFETCH, with IMEM_ADDRESS changing on that edge.
- Simultaneous RESET release and a clock edge: the edge is ignored.

## Test plan
- Reset: assert RESET=0 with PC=0 → BUSYWAIT=0, IMEM_READ=0, counters 0. After release, PC=0x000 → BUSYWAIT=1 in the same cycle.
- Cold miss, PREFETCH=0, memory latency 5 cycles: PC=0x000 → IMEM_ADDRESS=0, IMEM_READ held 6 cycles. Then PC 0x000, 0x004, 0x008, 0x00C return words 0–3 with no stall. Counters: MISS_COUNT=1, HIT_COUNT=4.
- Conflict: fill 0x000, then PC=0x080 (index 0, tag 1) → miss, block 8 fetched. PC=0x000 again → miss; MISS_COUNT=3.
- Prefetch, PREFETCH=1: miss at 0x000.
  - After the fill, IMEM_ADDRESS=1 with IMEM_READ still high.
  - PC=0x004 hits during the prefetch.
  - PC=0x010 stalls until prefetch completion, then hits.
  - Final MISS_COUNT=1.
- Wrap, PREFETCH=1: miss at 0x3F0 (block 63) → prefetch IMEM_ADDRESS=0. Afterwards PC=0x000 hits.
- Reset mid-fill: drive RESET=0 while IMEM_READ=1 → IMEM_READ=0 immediately. After release, the same PC misses again and MISS_COUNT=1.
